// File: rtl/seg_pkg.sv
// Shared definitions for the BCD / 7-segment display path: segment codes,
// nibble width, converter FSM states and an elaboration-time helper.
package seg_pkg;

    localparam int unsigned NIB_W = 4;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_seg_conv_seg7_dec.sv
// Combinational BCD nibble to active-low 7-segment decoder with blank override.
module seg7_dec
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    input  logic             blank_i,
    output logic [6:0]       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (nib_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_seg_conv.sv
// Sequential double-dabble binary-to-BCD converter with registered per-digit
// 7-segment outputs, driven by a start/busy/done handshake.
module bcd_seg_conv
    import seg_pkg::*;
#(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned DIGITS   = 4,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int unsigned BCD_W = DIGITS * NIB_W;
    localparam int unsigned SR_W  = BCD_W + WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    if (WIDTH > 63 || (64'd1 << WIDTH) > pow10(DIGITS)) begin : g_width_check
        $error("bcd_seg_conv: WIDTH does not fit in DIGITS decimal digits");
    end

    function automatic logic [7*DIGITS-1:0] reset_seg();
        logic [7*DIGITS-1:0] s;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            s[7*i +: 7] = (i == 0 || !BLANK_LZ) ? SEG_0 : SEG_BLANK;
        end
        return s;
    endfunction

    localparam logic [7*DIGITS-1:0] SEG_RST = reset_seg();

    state_t               state_q;
    logic [SR_W-1:0]      sr_q;
    logic [SR_W-1:0]      sr_corr;
    logic [SR_W-1:0]      sr_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [BCD_W-1:0]     bcd_d;
    logic [7*DIGITS-1:0]  seg_q;
    logic [7*DIGITS-1:0]  seg_d;
    logic [DIGITS-1:0]    blank;
    logic                 upper_zero;

    // Add-3 correction and the shift happen in the same cycle.
    always_comb begin
        sr_corr = sr_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sr_q[WIDTH + NIB_W*i +: NIB_W] >= 4'd5) begin
                sr_corr[WIDTH + NIB_W*i +: NIB_W] = sr_q[WIDTH + NIB_W*i +: NIB_W] + 4'd3;
            end
        end
        sr_d = sr_corr << 1;
    end

    assign bcd_d = sr_d[SR_W-1 -: BCD_W];

    // Blank flags scan from the most significant digit down; digit 0 never blanks.
    always_comb begin
        upper_zero = 1'b1;
        blank      = '0;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            upper_zero = upper_zero && (bcd_d[NIB_W*(DIGITS-1-j) +: NIB_W] == '0);
            if (j != DIGITS - 1) begin
                blank[DIGITS-1-j] = BLANK_LZ && upper_zero;
            end
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
        seg7_dec u_dec (
            .nib_i   (bcd_d[NIB_W*gi +: NIB_W]),
            .blank_i (blank[gi]),
            .seg_o   (seg_d[7*gi +: 7])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            seg_q   <= SEG_RST;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q    <= {{BCD_W{1'b0}}, bin};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        bcd_q   <= bcd_d;
                        seg_q   <= seg_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_bcd_seg_conv.sv
// Scoreboard bench for bcd_seg_conv: two instances (blanking on/off) share stimulus;
// expected results come from a decimal-arithmetic reference model.
module tb_bcd_seg_conv;

    typedef struct {
        logic [15:0] bcd;
        logic [27:0] seg1;
        logic [27:0] seg0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] bin = '0;
    logic        busy1, done1, busy0, done0;
    logic [15:0] bcd1, bcd0;
    logic [27:0] seg1, seg0;

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb[$];
    logic [15:0] prev_bcd = '0;

    logic [6:0] SEG_TBL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    bcd_seg_conv #(.WIDTH(12), .DIGITS(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy1), .done(done1), .bcd(bcd1), .seg(seg1)
    );

    bcd_seg_conv #(.WIDTH(12), .DIGITS(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy0), .done(done0), .bcd(bcd0), .seg(seg0)
    );

    always #5 clk = ~clk;

    // Digit i is (v / 10^i) % 10; blanked (i>0) exactly when v < 10^i.
    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned p;
        int unsigned d;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            d = (v / p) % 10;
            e.bcd[4*i +: 4]  = 4'(d);
            e.seg0[7*i +: 7] = SEG_TBL[d];
            e.seg1[7*i +: 7] = (i > 0 && v < p) ? 7'b1111111 : SEG_TBL[d];
            p = p * 10;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and watches output stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_bcd <= bcd1;
        end else begin
            checks++;
            if (busy1 && done1) begin
                errors++;
                $display("FAIL busy_done_overlap: busy=%b done=%b", busy1, done1);
            end
            if (done1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: bcd=%h with empty scoreboard", bcd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checks += 4;
                    if (bcd1 !== e.bcd) begin
                        errors++; $display("FAIL bcd: got %h expected %h", bcd1, e.bcd);
                    end
                    if (seg1 !== e.seg1) begin
                        errors++; $display("FAIL seg_blank: got %b expected %b", seg1, e.seg1);
                    end
                    if (bcd0 !== e.bcd || done0 !== 1'b1) begin
                        errors++; $display("FAIL bcd_noblank: got %h done %b expected %h", bcd0, done0, e.bcd);
                    end
                    if (seg0 !== e.seg0) begin
                        errors++; $display("FAIL seg_noblank: got %b expected %b", seg0, e.seg0);
                    end
                end
            end else begin
                checks++;
                if (bcd1 !== prev_bcd) begin
                    errors++;
                    $display("FAIL bcd_hold: got %h expected %h outside done", bcd1, prev_bcd);
                end
            end
            prev_bcd <= bcd1;
        end
    end

    task automatic wait_done(input bit noise);
        int n;
        int bc;
        n  = 0;
        bc = 0;
        while (!done1 && n < 20) begin
            if (busy1) bc++;
            if (noise) begin
                start = (n < 11) ? 1'($urandom) : 1'b0;
                bin   = 12'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        if (noise) start = 1'b0;
        chk("latency", n, 12);
        chk("busy_cycles", bc, 12);
    endtask

    task automatic conv(input int unsigned b, input bit noise);
        bin   = 12'(b);
        start = 1'b1;
        sb.push_back(model(b));
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(noise);
    endtask

    initial begin
        bit saw_done;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_bcd", bcd1, 0);
        chk("rst_seg_blank", seg1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
        chk("rst_seg_noblank", seg0, {4{7'b1000000}});
        rst = 1'b0;
        @(posedge clk); #1;

        conv(0, 0);
        conv(4095, 0);
        chk("bcd_4095", bcd1, 16'h4095);
        conv(7, 0);
        conv(42, 0);
        conv(100, 0);

        // start held high: back-to-back conversions, bin changes mid-flight
        bin   = 12'd1234;
        start = 1'b1;
        sb.push_back(model(1234));
        @(posedge clk); #1;
        bin = 12'd2500;
        sb.push_back(model(2500));
        wait_done(0);
        @(posedge clk); #1;
        start = 1'b0;
        bin   = 12'($urandom);
        wait_done(0);

        // reset mid-conversion aborts it
        bin   = 12'd999;
        start = 1'b1;
        sb.push_back(model(999));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy1, 0);
        chk("abort_bcd", bcd1, 0);
        chk("abort_done", done1, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done1) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);
        conv(58, 0);
        chk("bcd_58", bcd1, 16'h0058);

        for (int i = 0; i < 25; i++) begin
            conv($urandom_range(0, 4095), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        conv(9, 1);
        conv(10, 0);
        conv(999, 0);
        conv(1000, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_seg_conv.md
Name: bcd_seg_conv

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble), with per-digit 7-segment encoding.
- Sits downstream of the ALU datapath. Consumes the 2*width-bit result or the 6-bit operands and drives the board's 7-segment displays.
- Uses a start/busy/done handshake, so one instance can be time-shared between operand and result display.

Parameters:
- WIDTH, 12, bit width of the binary input. Legal only if 2^WIDTH-1 <= 10^DIGITS-1; this is checked at elaboration.
- DIGITS, 4, number of BCD digits and 7-segment displays driven.
- BLANK_LZ, 1, when 1 leading-zero digits are blanked; digit 0 is never blanked.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request conversion of bin. Sampled only in IDLE.
- bin  input  WIDTH  unsigned binary value. Captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd/seg hold the new result.
- bcd  output  4*DIGITS  packed BCD; digit 0 (units) is in bits [3:0].
- seg  output  7*DIGITS  per digit {g,f,e,d,c,b,a}, active-low; digit 0 is in bits [6:0].

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0; done=0; bcd=0.
  - seg: digit 0 = 7'b1000000 ("0"). Other digits = 7'b1111111 (blank) if BLANK_LZ=1, else 7'b1000000.
  - Reset mid-conversion aborts it; no done pulse is produced.
- FSM states are IDLE and SHIFT.
- IDLE, start=1 at edge k:
  - Load shift register {DIGITS*4 zeros, bin} and set cnt=0.
  - Go to SHIFT; busy=1 from edge k.
- SHIFT, each edge:
  - Every BCD nibble >= 5 gets +3 (correction is combinational within the same cycle).
  - Then the whole register shifts left by 1; cnt increments.
- Completion, at the edge where cnt reaches WIDTH (edge k+WIDTH):
  - bcd and seg are registered with the final value.
  - done=1 and busy=0 for the cycle following that edge.
  - Return to IDLE.
- Latency: done is observed high WIDTH cycles after the start edge (12 for the default).
- busy and done are never high in the same cycle.
- start while busy=1 is ignored and not queued.
- start is accepted in the done cycle (state IDLE), giving back-to-back conversions with zero bubble.
- bcd and seg hold their last result until the next completion; they never show intermediate values.
- Leading-zero blanking (BLANK_LZ=1): digit i>0 is blanked iff it and all higher digits are 0. It is computed before the output register.
- Segment codes, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111. A nibble > 9 is unreachable; encode it as blank.
- Internal widths: shift register DIGITS*4+WIDTH bits; cnt is clog2(WIDTH+1) bits.

Decomposition:
- Shared package seg_pkg holds:
  - segment-code constants SEG_0..SEG_9 and SEG_BLANK;
  - BCD nibble width constant (4);
  - the FSM state enum (IDLE, SHIFT).
- One sub-module, seg7_dec: combinational 4-bit nibble plus blank flag in, 7-bit active-low code out. It is instantiated DIGITS times via generate.

Test Plan:
- Reset, then bin=0, start pulse:
  - done after 12 cycles; bcd=16'h0000.
  - seg = {1111111,1111111,1111111,1000000}.
- bin=4095, start:
  - bcd=16'h4095; seg digits 3..0 = 0011001, 1000000, 0010000, 0010010.
  - busy is high for exactly 12 cycles.
- bin=1234 then start held high continuously:
  - first result bcd=16'h1234.
  - A second conversion starts in the done cycle; done pulses every 13 cycles.
  - Changing bin mid-conversion does not alter the in-flight result.
- bin=7 with BLANK_LZ=1 gives seg upper three digits blank and digit 0 = 1111000. With BLANK_LZ=0, upper digits = 1000000.
- Start bin=999, assert rst at cycle 5:
  - busy=0 and bcd=0 immediately; no done pulse.
  - A new start with bin=58 yields bcd=16'h0058.
- Previous result 16'h0042, then a start pulse with bin=100: bcd stays 0042 until done, then becomes 0100. No other intermediate value ever appears.
